// File: rtl/mem_port_arbiter.sv
// Single shared memory port arbiter: MEM-over-IF priority, round-robin when both contend.
// Optional feature: define ARB_TIMEOUT_EN to abort accesses that wait TIMEOUT cycles for m_ack.
module mem_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          mem_req,
    input  logic          mem_rw,
    input  logic [1:0]    mem_size,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_ack,
    output logic          m_req,
    output logic          m_rw,
    output logic [1:0]    m_size,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic [1:0]    grant,
    output logic          stall,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, DONE} state_t;

    state_t state, next_state;
    logic   last_mem;
    logic   take_mem, take_if, complete;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
    logic          abort;
`endif

    // MEM wins unless it also held the previous grant while IF is waiting
    always_comb begin
        next_state = state;
        take_mem   = 1'b0;
        take_if    = 1'b0;
        complete   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        abort      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (mem_req && !(last_mem && if_req)) begin
                    take_mem   = 1'b1;
                    next_state = MEM_BUSY;
                end else if (if_req) begin
                    take_if    = 1'b1;
                    next_state = IF_BUSY;
                end
            end
            IF_BUSY, MEM_BUSY: begin
                if (m_ack) begin
                    complete   = 1'b1;
                    next_state = DONE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    abort      = 1'b1;
                    next_state = DONE;
                end
`endif
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_mem  <= 1'b0;
            m_rw      <= 1'b0;
            m_size    <= 2'b00;
            m_addr    <= '0;
            m_wdata   <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if (take_mem) begin
                last_mem <= 1'b1;
                m_rw     <= mem_rw;
                m_size   <= mem_size;
                m_addr   <= mem_addr;
                m_wdata  <= mem_wdata;
            end else if (take_if) begin
                last_mem <= 1'b0;
                m_rw     <= 1'b0;
                m_size   <= 2'b10;
                m_addr   <= if_addr;
            end
            // stores complete without touching the load data register
            if (complete) begin
                if (state == IF_BUSY) if_rdata  <= m_rdata;
                else if (!m_rw)       mem_rdata <= m_rdata;
            end
`ifdef ARB_TIMEOUT_EN
            if (abort) begin
                if (state == IF_BUSY) if_rdata  <= DW'(32'hDEADBEEF);
                else                  mem_rdata <= DW'(32'hDEADBEEF);
            end
`endif
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (take_mem || take_if)
                wait_cnt <= '0;
            else if ((state == IF_BUSY || state == MEM_BUSY) && !m_ack)
                wait_cnt <= wait_cnt + 1'b1;
            if (abort) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    assign m_req   = (state == IF_BUSY) || (state == MEM_BUSY);
    assign grant   = {state == MEM_BUSY, state == IF_BUSY};
    assign if_ack  = (state == DONE) && !last_mem;
    assign mem_ack = (state == DONE) && last_mem;
    assign stall   = (if_req & ~if_ack) | (mem_req & ~mem_ack);

endmodule
